sca_stim_ctrl: RTL and testbench

Parametrised stimulus controller for side-channel characterisation of a locked DUT. It replaces the fixed static/flip-clock input drive with a single-clock engine. Each DUT input is configured over a serial link as static, toggling, pseudo-random or one-shot pulse. The engine runs a bounded or continuous stimulus burst with a scope trigger, then captures the DUT outputs and shifts them back out serially. It sits between the board-level pin wrapper and the DUT instance(s).

---
 rtl/sca_stim_ctrl_if.sv | 38 +++
 rtl/sca_stim_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sca_stim_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sca_stim_ctrl_if.sv
// rtl/sca_stim_ctrl_if.sv - serial link and DUT pin bundle for the stimulus controller
//
// Purpose: groups the config link, run control and DUT-facing signals.
// Ports (signals):
//   sca_data_in  host -> ctrl  serial config bit
//   sca_frame    host -> ctrl  config shift window
//   sca_start    host -> ctrl  run start/stop level
//   dut_outputs  DUT  -> ctrl  DUT response
//   dut_inputs   ctrl -> DUT   registered DUT drive
//   sca_data_out ctrl -> host  serial echo / readback
//   trigger      ctrl -> host  one-cycle scope trigger
//   xor_out      ctrl -> host  XOR of last captured outputs
//   busy         ctrl -> host  run/capture/readback in progress
// Modports: master (host/bench side), slave (controller side).
interface sca_stim_ctrl_if #(
  parameter int NUM_INS  = 8,
  parameter int NUM_OUTS = 8
);
  logic                sca_data_in;
  logic                sca_frame;
  logic                sca_start;
  logic [NUM_OUTS-1:0] dut_outputs;
  logic [NUM_INS-1:0]  dut_inputs;
  logic                sca_data_out;
  logic                trigger;
  logic                xor_out;
  logic                busy;

  modport master (
    output sca_data_in, sca_frame, sca_start, dut_outputs,
    input  dut_inputs, sca_data_out, trigger, xor_out, busy
  );

  modport slave (
    input  sca_data_in, sca_frame, sca_start, dut_outputs,
    output dut_inputs, sca_data_out, trigger, xor_out, busy
  );
endinterface

// File: rtl/sca_stim_ctrl.sv
// rtl/sca_stim_ctrl.sv - side-channel stimulus engine with serial config and readback
//
// Purpose: shifts in a per-input stimulus config, runs a bounded or continuous
// burst (static/toggle/LFSR/pulse per input) with a scope trigger, captures the
// DUT outputs and shifts them back out MSB first.
// Ports:
//   sca_clk  sole clock, rising edge
//   reset    asynchronous, active-low
//   bus      sca_stim_ctrl_if.slave (link, run control and DUT pins)
module sca_stim_ctrl #(
  parameter int NUM_INS  = 8,
  parameter int NUM_OUTS = 8
) (
  input logic           sca_clk,
  input logic           reset,
  sca_stim_ctrl_if.slave bus
);
  localparam int          CFG_LEN   = 3 * NUM_INS + 16;
  localparam int          BW        = $clog2(NUM_OUTS + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, SHIFT_OUT} state_t;

  state_t              state, state_nxt;
  logic [CFG_LEN-1:0]  shift_reg, shift_reg_nxt;
  logic [CFG_LEN-1:0]  cfg, cfg_nxt;
  logic [NUM_OUTS-1:0] out_sr, out_sr_nxt;
  logic [NUM_INS-1:0]  drive, drive_nxt;
  logic [15:0]         lfsr, lfsr_nxt, lfsr_step;
  logic [7:0]          run_cnt, run_cnt_nxt;
  logic [7:0]          tog_cnt, tog_cnt_nxt;
  logic                tog_phase, tog_phase_nxt, tog_phase_run;
  logic [BW-1:0]       bit_cnt, bit_cnt_nxt;
  logic                start_q, start_edge;
  logic                trig, trig_nxt;
  logic                xr, xr_nxt;

  logic [NUM_INS-1:0]  cfg_s;
  logic [7:0]          cfg_div;
  logic [7:0]          cfg_run_len;

  assign cfg_s       = cfg[NUM_INS-1:0];
  assign cfg_div     = cfg[3*NUM_INS +: 8];
  assign cfg_run_len = cfg[3*NUM_INS+8 +: 8];

  assign start_edge  = bus.sca_start & ~start_q;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  assign lfsr_step   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // Phase to use in the next RUN cycle: flips when the reload counter expires.
  assign tog_phase_run = tog_phase ^ (tog_cnt == 8'd0);

  function automatic logic [NUM_INS-1:0] stim_value(
    input logic [CFG_LEN-1:0] c,
    input logic               first,
    input logic               phase,
    input logic [15:0]        lf
  );
    logic [NUM_INS-1:0] v;
    logic [1:0]         m;
    v = '0;
    for (int i = 0; i < NUM_INS; i++) begin
      m = c[NUM_INS + 2*i +: 2];
      case (m)
        2'b00:   v[i] = c[i];
        2'b01:   v[i] = c[i] ^ phase;
        2'b10:   v[i] = lf[i % 16];
        default: v[i] = first ? ~c[i] : c[i];
      endcase
    end
    return v;
  endfunction

  always_ff @(posedge sca_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      cfg       <= '0;
      out_sr    <= '0;
      drive     <= '0;
      lfsr      <= LFSR_SEED;
      run_cnt   <= '0;
      tog_cnt   <= '0;
      tog_phase <= 1'b0;
      bit_cnt   <= '0;
      start_q   <= 1'b0;
      trig      <= 1'b0;
      xr        <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_reg_nxt;
      cfg       <= cfg_nxt;
      out_sr    <= out_sr_nxt;
      drive     <= drive_nxt;
      lfsr      <= lfsr_nxt;
      run_cnt   <= run_cnt_nxt;
      tog_cnt   <= tog_cnt_nxt;
      tog_phase <= tog_phase_nxt;
      bit_cnt   <= bit_cnt_nxt;
      start_q   <= bus.sca_start;
      trig      <= trig_nxt;
      xr        <= xr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_reg_nxt = shift_reg;
    cfg_nxt       = cfg;
    out_sr_nxt    = out_sr;
    drive_nxt     = cfg_s;
    lfsr_nxt      = lfsr;
    run_cnt_nxt   = run_cnt;
    tog_cnt_nxt   = tog_cnt;
    tog_phase_nxt = tog_phase;
    bit_cnt_nxt   = bit_cnt;
    trig_nxt      = 1'b0;
    xr_nxt        = xr;

    case (state)
      IDLE: begin
        // Frame has priority; a coincident start edge is simply lost.
        if (bus.sca_frame) begin
          state_nxt     = LOAD;
          shift_reg_nxt = {shift_reg[CFG_LEN-2:0], bus.sca_data_in};
        end else if (start_edge) begin
          state_nxt     = RUN;
          trig_nxt      = 1'b1;
          lfsr_nxt      = LFSR_SEED;
          tog_cnt_nxt   = cfg_div;
          tog_phase_nxt = 1'b0;
          run_cnt_nxt   = cfg_run_len - 8'd1;
          drive_nxt     = stim_value(cfg, 1'b1, 1'b0, LFSR_SEED);
        end
      end

      LOAD: begin
        if (bus.sca_frame) begin
          shift_reg_nxt = {shift_reg[CFG_LEN-2:0], bus.sca_data_in};
        end else begin
          cfg_nxt   = shift_reg;
          drive_nxt = shift_reg[NUM_INS-1:0];
          state_nxt = IDLE;
        end
      end

      RUN: begin
        lfsr_nxt      = lfsr_step;
        tog_phase_nxt = tog_phase_run;
        tog_cnt_nxt   = (tog_cnt == 8'd0) ? cfg_div : tog_cnt - 8'd1;
        if ((cfg_run_len != 8'd0) ? (run_cnt == 8'd0) : start_edge) begin
          state_nxt = CAPTURE;
        end else begin
          if (cfg_run_len != 8'd0) begin
            run_cnt_nxt = run_cnt - 8'd1;
          end
          drive_nxt = stim_value(cfg, 1'b0, tog_phase_run, lfsr_step);
        end
      end

      CAPTURE: begin
        out_sr_nxt  = bus.dut_outputs;
        xr_nxt      = ^bus.dut_outputs;
        bit_cnt_nxt = BW'(NUM_OUTS - 1);
        state_nxt   = SHIFT_OUT;
      end

      SHIFT_OUT: begin
        out_sr_nxt = out_sr << 1;
        if (bit_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt - BW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Echo in LOAD lets several controllers be daisy-chained on one link.
  always_comb begin
    bus.sca_data_out = 1'b0;
    if (state == LOAD) begin
      bus.sca_data_out = shift_reg[CFG_LEN-1];
    end else if (state == SHIFT_OUT) begin
      bus.sca_data_out = out_sr[NUM_OUTS-1];
    end
  end

  assign bus.busy       = (state == RUN) || (state == CAPTURE) || (state == SHIFT_OUT);
  assign bus.dut_inputs = drive;
  assign bus.trigger    = trig;
  assign bus.xor_out    = xr;
endmodule

// File: tb/tb_sca_stim_ctrl.sv
// tb/tb_sca_stim_ctrl.sv - self-checking bench for sca_stim_ctrl
module tb_sca_stim_ctrl;
  localparam int NI      = 8;
  localparam int NO      = 8;
  localparam int CFG_LEN = 3 * NI + 16;

  typedef struct {
    logic [7:0]  s;
    logic [15:0] modes;
    logic [7:0]  div;
    logic [7:0]  run_len;
    int          stop_after;
    logic [7:0]  dut_out;
    bit          poke_shift;
    logic [7:0]  exp_first;
    logic        exp_xor;
  } vec_t;

  logic sca_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [CFG_LEN-1:0] m_sr = '0;
  logic [7:0]         m_s  = '0;
  logic [7:0]         exp_in_q[$];
  logic               exp_bit_q[$];
  vec_t               vecs[7];

  sca_stim_ctrl_if #(.NUM_INS(NI), .NUM_OUTS(NO)) bus ();

  sca_stim_ctrl #(.NUM_INS(NI), .NUM_OUTS(NO)) dut (
    .sca_clk (sca_clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  always #5 sca_clk = ~sca_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sca_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [7:0] model_drive(input vec_t v, input int k, input logic [15:0] l);
    logic [7:0] d;
    logic [1:0] m;
    d = '0;
    for (int i = 0; i < NI; i++) begin
      m = v.modes[2*i +: 2];
      case (m)
        2'b00:   d[i] = v.s[i];
        2'b01:   d[i] = v.s[i] ^ (((k / (int'(v.div) + 1)) % 2) == 1);
        2'b10:   d[i] = l[i % 16];
        default: d[i] = (k == 0) ? ~v.s[i] : v.s[i];
      endcase
    end
    return d;
  endfunction

  function automatic logic [CFG_LEN-1:0] make_cfg(input vec_t v);
    return {v.run_len, v.div, v.modes, v.s};
  endfunction

  task automatic load_cfg(input logic [CFG_LEN-1:0] c);
    for (int b = CFG_LEN - 1; b >= 0; b--) begin
      bus.sca_frame   = 1'b1;
      bus.sca_data_in = c[b];
      tick();
      m_sr = {m_sr[CFG_LEN-2:0], c[b]};
      check("load_echo", bus.sca_data_out, m_sr[CFG_LEN-1]);
      check("load_busy", bus.busy, 1'b0);
      check("load_trigger", bus.trigger, 1'b0);
    end
    check("load_hold_s", bus.dut_inputs, m_s);
    bus.sca_frame   = 1'b0;
    bus.sca_data_in = 1'b0;
    tick();
    m_s = c[7:0];
    check("commit_s", bus.dut_inputs, m_s);
    check("commit_echo_off", bus.sca_data_out, 1'b0);
  endtask

  task automatic do_run(input vec_t v);
    int          r;
    logic [15:0] l;
    r = (v.run_len != 0) ? int'(v.run_len) : v.stop_after;
    l = 16'hACE1;
    for (int k = 0; k < r; k++) begin
      exp_in_q.push_back(model_drive(v, k, l));
      l = lfsr_next(l);
    end
    for (int b = NO - 1; b >= 0; b--) exp_bit_q.push_back(v.dut_out[b]);
    bus.dut_outputs = v.dut_out;
    bus.sca_start   = 1'b1;
    tick();
    check("first_drive", bus.dut_inputs, v.exp_first);
    for (int k = 0; k < r; k++) begin
      check("run_trigger", bus.trigger, (k == 0));
      check("run_busy", bus.busy, 1'b1);
      check("run_data_out", bus.sca_data_out, 1'b0);
      if (exp_in_q.size() == 0) check("run_queue", 0, 1);
      else check("run_drive", bus.dut_inputs, exp_in_q.pop_front());
      bus.sca_start = (v.run_len == 0 && k == r - 1) ? 1'b1 : 1'b0;
      tick();
    end
    check("cap_busy", bus.busy, 1'b1);
    check("cap_drive", bus.dut_inputs, v.s);
    check("cap_data_out", bus.sca_data_out, 1'b0);
    tick();
    for (int b = 0; b < NO; b++) begin
      if (v.poke_shift && b == 2) bus.sca_start = 1'b1;
      check("shift_busy", bus.busy, 1'b1);
      check("shift_trigger", bus.trigger, 1'b0);
      if (exp_bit_q.size() == 0) check("shift_queue", 0, 1);
      else check("readback", bus.sca_data_out, exp_bit_q.pop_front());
      tick();
    end
    check("done_busy", bus.busy, 1'b0);
    check("done_xor", bus.xor_out, v.exp_xor);
    check("done_drive", bus.dut_inputs, v.s);
    bus.sca_start = 1'b0;
    tick();
    tick();
    check("idle_busy", bus.busy, 1'b0);
    check("idle_trigger", bus.trigger, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_inputs"}, bus.dut_inputs, 8'h00);
    check({name, "_data_out"}, bus.sca_data_out, 1'b0);
    check({name, "_trigger"}, bus.trigger, 1'b0);
    check({name, "_xor"}, bus.xor_out, 1'b0);
    check({name, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    vec_t v;
    //            s      modes     div    run_len stop dut_out poke first  xor
    vecs[0] = '{8'hA5, 16'h0000, 8'd0, 8'd3, 0,  8'h5A, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 16'h0001, 8'd2, 8'd9, 0,  8'h81, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'h00, 16'hAAAA, 8'd0, 8'd4, 0,  8'h01, 1'b0, 8'hE1, 1'b1};
    vecs[3] = '{8'h00, 16'hAAAA, 8'd0, 8'd4, 0,  8'h01, 1'b0, 8'hE1, 1'b1};
    vecs[4] = '{8'h0F, 16'hFFFF, 8'd0, 8'd1, 0,  8'hFF, 1'b0, 8'hF0, 1'b0};
    vecs[5] = '{8'h33, 16'h0000, 8'd0, 8'd0, 20, 8'h3C, 1'b0, 8'h33, 1'b0};
    vecs[6] = '{8'h96, 16'h0039, 8'd0, 8'd5, 0,  8'h07, 1'b0, 8'h90, 1'b1};

    bus.sca_data_in = 1'b0;
    bus.sca_frame   = 1'b0;
    bus.sca_start   = 1'b0;
    bus.dut_outputs = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    for (int n = 0; n < 7; n++) begin
      load_cfg(make_cfg(vecs[n]));
      do_run(vecs[n]);
    end

    // Frame and start edge in the same IDLE cycle: LOAD wins, no run.
    v = vecs[0];
    v.s = 8'h5C;
    bus.sca_start = 1'b1;
    load_cfg(make_cfg(v));
    tick();
    check("frame_start_busy", bus.busy, 1'b0);
    check("frame_start_trigger", bus.trigger, 1'b0);
    check("frame_start_s", bus.dut_inputs, 8'h5C);
    bus.sca_start = 1'b0;
    tick();

    // Reset in the middle of a continuous RUN.
    v = vecs[5];
    v.s = 8'hA5;
    load_cfg(make_cfg(v));
    bus.sca_start = 1'b1;
    tick();
    bus.sca_start = 1'b0;
    repeat (5) tick();
    check("mid_run_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_run");
    tick();
    rst_n = 1'b1;
    m_sr = '0;
    m_s  = '0;
    tick();
    check_all_zero("rst_run_after");

    // Reset in the middle of SHIFT_OUT: no partial readback afterwards.
    v = vecs[0];
    v.run_len = 8'd2;
    v.dut_out = 8'hFF;
    v.s       = 8'h18;
    load_cfg(make_cfg(v));
    bus.dut_outputs = 8'h01;
    bus.sca_start   = 1'b1;
    tick();
    bus.sca_start = 1'b0;
    repeat (4) tick();
    check("mid_shift_busy", bus.busy, 1'b1);
    check("mid_shift_xor", bus.xor_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_shift");
    tick();
    rst_n = 1'b1;
    m_sr = '0;
    m_s  = '0;
    for (int k = 0; k < NO; k++) begin
      tick();
      check("rst_shift_data_out", bus.sca_data_out, 1'b0);
      check("rst_shift_busy", bus.busy, 1'b0);
    end
    check("rst_shift_cfg", bus.dut_inputs, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
